// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue
//   Producer side of the register-file write port. Each execute/memory result
//   that writes a register is resolved to its destination (rt or rd), sub-word
//   loads are extended, and the result is queued in a small FIFO. The queue
//   drains one write per cycle over a write/ack handshake. Decode can look up
//   two registers against the queued (in-flight) results to forward or stall.
//
// Ports
//   clk, rst_n                      clock, synchronous active-low reset
//   in_valid / in_ready             result handshake (in_ready = not full)
//   in_opcode, in_rt, in_rd,
//   in_regdst, in_regwrite,
//   in_byte_off, in_data            result fields
//   wb_write, wb_reg, wb_data       head entry presented to the register file
//   wb_ack                          register file consumed the head this cycle
//   chk_reg_1/2                     lookup registers
//   chk_hit_1/2, chk_data_1/2       youngest queued result for each lookup
//   pending_count                   number of queued entries
module reg_writeback_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_opcode,
    input  logic [4:0]       in_rt,
    input  logic [4:0]       in_rd,
    input  logic             in_regdst,
    input  logic             in_regwrite,
    input  logic [1:0]       in_byte_off,
    input  logic [31:0]      in_data,
    output logic             wb_write,
    output logic [4:0]       wb_reg,
    output logic [31:0]      wb_data,
    input  logic             wb_ack,
    input  logic [4:0]       chk_reg_1,
    input  logic [4:0]       chk_reg_2,
    output logic             chk_hit_1,
    output logic             chk_hit_2,
    output logic [31:0]      chk_data_1,
    output logic [31:0]      chk_data_2,
    output logic [CNT_W-1:0] pending_count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [4:0]       reg_mem  [DEPTH];
    logic [31:0]      data_mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    logic [4:0]  dest;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] ext_data;
    logic        push;
    logic        pop;

    // Destination, sub-word selection and load extension.
    always_comb begin
        dest = in_regdst ? in_rd : in_rt;
        case (in_byte_off)
            2'd0:    sel_byte = in_data[7:0];
            2'd1:    sel_byte = in_data[15:8];
            2'd2:    sel_byte = in_data[23:16];
            default: sel_byte = in_data[31:24];
        endcase
        // Half-word loads ignore the low offset bit.
        sel_half = in_byte_off[1] ? in_data[31:16] : in_data[15:0];
        case (in_opcode)
            6'h20:   ext_data = {{24{sel_byte[7]}}, sel_byte};
            6'h24:   ext_data = {24'b0, sel_byte};
            6'h21:   ext_data = {{16{sel_half[15]}}, sel_half};
            6'h25:   ext_data = {16'b0, sel_half};
            default: ext_data = in_data;
        endcase
    end

    // A full queue refuses input even when the head pops in the same cycle,
    // so in_ready never depends on wb_ack.
    assign in_ready = (count_reg != CNT_W'(DEPTH));
    // Results that do not write a register (or target r0) are accepted but
    // silently dropped.
    assign push = in_valid && in_ready && in_regwrite && (dest != 5'd0);
    assign pop  = (count_reg != '0) && wb_ack;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Entry storage has no reset; validity is tracked by count_reg alone.
    always_ff @(posedge clk) begin
        if (push) begin
            reg_mem[wr_ptr_reg]  <= dest;
            data_mem[wr_ptr_reg] <= ext_data;
        end
    end

    assign wb_write      = (count_reg != '0);
    assign wb_reg        = wb_write ? reg_mem[rd_ptr_reg]  : 5'd0;
    assign wb_data       = wb_write ? data_mem[rd_ptr_reg] : 32'd0;
    assign pending_count = count_reg;

    // Lookup: slots are visited by age (0 = head/oldest). Later ages override
    // earlier ones in the scan below, so the youngest match wins.
    logic [DEPTH-1:0] match_1;
    logic [DEPTH-1:0] match_2;
    logic [31:0]      age_data [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
            logic [PTR_W-1:0] slot;
            logic             live;
            assign slot         = rd_ptr_reg + PTR_W'(gi);
            assign live         = (CNT_W'(gi) < count_reg);
            assign match_1[gi]  = live && (chk_reg_1 != 5'd0) && (reg_mem[slot] == chk_reg_1);
            assign match_2[gi]  = live && (chk_reg_2 != 5'd0) && (reg_mem[slot] == chk_reg_2);
            assign age_data[gi] = data_mem[slot];
        end
    endgenerate

    always_comb begin
        chk_hit_1  = 1'b0;
        chk_hit_2  = 1'b0;
        chk_data_1 = 32'd0;
        chk_data_2 = 32'd0;
        for (int k = 0; k < DEPTH; k++) begin
            if (match_1[k]) begin
                chk_hit_1  = 1'b1;
                chk_data_1 = age_data[k];
            end
            if (match_2[k]) begin
                chk_hit_2  = 1'b1;
                chk_data_2 = age_data[k];
            end
        end
    end
endmodule

// File: tb/tb_reg_writeback_queue.sv
module tb_reg_writeback_queue;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_opcode;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic        in_regdst;
    logic        in_regwrite;
    logic [1:0]  in_byte_off;
    logic [31:0] in_data;
    logic        wb_write;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        wb_ack;
    logic [4:0]  chk_reg_1;
    logic [4:0]  chk_reg_2;
    logic        chk_hit_1;
    logic        chk_hit_2;
    logic [31:0] chk_data_1;
    logic [31:0] chk_data_2;
    logic [CNT_W-1:0] pending_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reg_writeback_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rt(in_rt), .in_rd(in_rd),
        .in_regdst(in_regdst), .in_regwrite(in_regwrite),
        .in_byte_off(in_byte_off), .in_data(in_data),
        .wb_write(wb_write), .wb_reg(wb_reg), .wb_data(wb_data), .wb_ack(wb_ack),
        .chk_reg_1(chk_reg_1), .chk_reg_2(chk_reg_2),
        .chk_hit_1(chk_hit_1), .chk_hit_2(chk_hit_2),
        .chk_data_1(chk_data_1), .chk_data_2(chk_data_2),
        .pending_count(pending_count)
    );

    // Reference model: an ordered list of pending (register, value) writes.
    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;
    ent_t q[$];

    function automatic logic [31:0] ext(input logic [5:0] op, input logic [1:0] off,
                                        input logic [31:0] d);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        sh = d >> (8 * off);
        b  = sh[7:0];
        h  = off[1] ? d[31:16] : d[15:0];
        case (op)
            6'h20:   return {{24{b[7]}}, b};
            6'h24:   return {24'h0, b};
            6'h21:   return {{16{h[15]}}, h};
            6'h25:   return {16'h0, h};
            default: return d;
        endcase
    endfunction

    // Expected output vector derived from the model list.
    function automatic logic [107:0] exp_out();
        logic        h1, h2;
        logic [31:0] d1, d2, wd;
        logic [4:0]  wr;
        h1 = 0; h2 = 0; d1 = 0; d2 = 0; wd = 0; wr = 0;
        for (int i = 0; i < q.size(); i++) begin
            if (chk_reg_1 != 0 && q[i].r == chk_reg_1) begin h1 = 1; d1 = q[i].d; end
            if (chk_reg_2 != 0 && q[i].r == chk_reg_2) begin h2 = 1; d2 = q[i].d; end
        end
        if (q.size() != 0) begin wr = q[0].r; wd = q[0].d; end
        return {q.size() != DEPTH, q.size() != 0, wr, wd, h1, h2, d1, d2, 3'(q.size())};
    endfunction

    function automatic logic [107:0] obs_out();
        return {in_ready, wb_write, wb_reg, wb_data, chk_hit_1, chk_hit_2,
                chk_data_1, chk_data_2, pending_count};
    endfunction

    // Advance one clock, applying the same edge to the model.
    task automatic tick();
        logic       accept;
        logic [4:0] dest;
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
        end else begin
            accept = in_valid && (q.size() < DEPTH);
            dest   = in_regdst ? in_rd : in_rt;
            if (q.size() != 0 && wb_ack) void'(q.pop_front());
            if (accept && in_regwrite && dest != 0)
                q.push_back('{r: dest, d: ext(in_opcode, in_byte_off, in_data)});
        end
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_opcode = 0; in_rt = 0; in_rd = 0; in_regdst = 0;
        in_regwrite = 0; in_byte_off = 0; in_data = 0; wb_ack = 0;
        chk_reg_1 = 0; chk_reg_2 = 0;
    endtask

    task automatic push(input logic [4:0] r, input logic [5:0] op,
                        input logic [1:0] off, input logic [31:0] d);
        in_valid = 1; in_regwrite = 1; in_regdst = 0; in_rt = r; in_rd = 0;
        in_opcode = op; in_byte_off = off; in_data = d;
        tick();
        in_valid = 0;
    endtask

    task automatic drain();
        in_valid = 0; wb_ack = 1;
        for (int i = 0; i < 8 && q.size() != 0; i++) tick();
        wb_ack = 0;
        #1;
        total++;
        if (pending_count !== 3'd0 || q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0", pending_count);
        end
    endtask

    task automatic test_reset();
        rst_n = 0; idle_inputs();
        tick(); tick();
        rst_n = 1;
        #1;
        total++;
        if (obs_out() !== exp_out() || wb_write !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset got=%h want=%h", obs_out(), exp_out());
        end
        $display("txn reset count=%0d ready=%0d", pending_count, in_ready);
    endtask

    task automatic test_reset_mid_drain();
        push(5'd3, 6'h00, 2'd0, 32'h11);
        push(5'd4, 6'h00, 2'd0, 32'h22);
        push(5'd6, 6'h00, 2'd0, 32'h33);
        wb_ack = 1; rst_n = 0;
        tick();
        rst_n = 1; wb_ack = 0;
        #1;
        total++;
        if (wb_write !== 1'b0 || pending_count !== 3'd0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_drain got=%b/%0d/%b want=0/0/1",
                     wb_write, pending_count, in_ready);
        end
        $display("txn reset_mid_drain count=%0d", pending_count);
    endtask

    task automatic test_extend();
        logic [5:0]  ops  [4] = '{6'h24, 6'h20, 6'h21, 6'h25};
        logic [1:0]  offs [4] = '{2'd2, 2'd2, 2'd2, 2'd0};
        logic [31:0] want [4] = '{32'h000000B2, 32'hFFFFFFB2, 32'hFFFFA1B2, 32'h0000C3D4};
        for (int i = 0; i < 4; i++) begin
            push(5'd5, ops[i], offs[i], 32'hA1B2C3D4);
            #1;
            total++;
            if (wb_reg !== 5'd5 || wb_data !== want[i] || obs_out() !== exp_out()) begin
                bad++;
                $display("FAIL extend op=%h got=%0d:%h want=5:%h", ops[i], wb_reg, wb_data, want[i]);
            end
            $display("txn extend op=%h off=%0d data=%h", ops[i], offs[i], wb_data);
            drain();
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) push(5'(i + 1), 6'h00, 2'd0, 32'(100 + i));
        #1;
        total++;
        if (in_ready !== 1'b0 || pending_count !== 3'd4) begin
            bad++;
            $display("FAIL full got=%b/%0d want=0/4", in_ready, pending_count);
        end
        push(5'd9, 6'h00, 2'd0, 32'hDEAD);
        #1;
        total++;
        if (pending_count !== 3'd4 || obs_out() !== exp_out()) begin
            bad++;
            $display("FAIL full_refuse got=%0d want=4", pending_count);
        end
        // Still full while popping: the offered entry must be refused.
        in_valid = 1; in_rt = 5'd9; in_regwrite = 1; in_data = 32'hBEEF; wb_ack = 1;
        tick();
        in_valid = 0; wb_ack = 0;
        #1;
        total++;
        if (in_ready !== 1'b1 || pending_count !== 3'd3 || wb_data !== 32'd101
            || obs_out() !== exp_out()) begin
            bad++;
            $display("FAIL full_pop got=%b/%0d/%h want=1/3/65", in_ready, pending_count, wb_data);
        end
        $display("txn full count=%0d", pending_count);
        drain();
    endtask

    task automatic test_lookup();
        push(5'd7, 6'h00, 2'd0, 32'd1);
        push(5'd7, 6'h00, 2'd0, 32'd2);
        chk_reg_1 = 5'd7; chk_reg_2 = 5'd0;
        #1;
        total++;
        if (chk_hit_1 !== 1'b1 || chk_data_1 !== 32'd2 || chk_hit_2 !== 1'b0
            || chk_data_2 !== 32'd0 || obs_out() !== exp_out()) begin
            bad++;
            $display("FAIL lookup got=%b:%h/%b want=1:2/0", chk_hit_1, chk_data_1, chk_hit_2);
        end
        $display("txn lookup r7 hit=%b data=%h", chk_hit_1, chk_data_1);
        // Head pops this cycle but still counts until the edge.
        chk_reg_2 = 5'd7; wb_ack = 1;
        #1;
        total++;
        if (chk_hit_2 !== 1'b1 || chk_data_2 !== 32'd2) begin
            bad++;
            $display("FAIL lookup_pop got=%b:%h want=1:2", chk_hit_2, chk_data_2);
        end
        drain();
        chk_reg_1 = 0; chk_reg_2 = 0;
    endtask

    task automatic test_filter();
        in_valid = 1; in_regwrite = 0; in_rt = 5'd8; in_data = 32'h55;
        tick();
        in_regwrite = 1; in_rt = 5'd0; in_rd = 5'd9; in_regdst = 0;
        tick();
        in_valid = 0;
        #1;
        total++;
        if (pending_count !== 3'd0 || wb_write !== 1'b0 || obs_out() !== exp_out()) begin
            bad++;
            $display("FAIL filter got=%0d/%b want=0/0", pending_count, wb_write);
        end
        $display("txn filter count=%0d", pending_count);
    endtask

    task automatic test_back_to_back();
        push(5'd1, 6'h00, 2'd0, 32'd99);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1; in_regwrite = 1; in_regdst = 1; in_rd = 5'((i % 7) + 1);
            in_opcode = 6'h00; in_data = 32'(100 + i); wb_ack = 1;
            #1;
            total++;
            if (pending_count !== 3'd1 || obs_out() !== exp_out()) begin
                bad++;
                $display("FAIL back_to_back i=%0d got=%h want=%h", i, obs_out(), exp_out());
            end
            $display("txn b2b i=%0d wb_reg=%0d wb_data=%0d", i, wb_reg, wb_data);
            tick();
        end
        in_regdst = 0;
        drain();
    endtask

    task automatic test_random();
        logic [5:0] ops [6] = '{6'h20, 6'h24, 6'h21, 6'h25, 6'h00, 6'h23};
        for (int i = 0; i < 300; i++) begin
            rst_n       = ($urandom_range(0, 49) != 0);
            in_valid    = $urandom_range(0, 1);
            in_opcode   = ops[$urandom_range(0, 5)];
            in_rt       = 5'($urandom_range(0, 7));
            in_rd       = 5'($urandom_range(0, 7));
            in_regdst   = $urandom_range(0, 1);
            in_regwrite = ($urandom_range(0, 5) != 0);
            in_byte_off = 2'($urandom_range(0, 3));
            in_data     = $urandom;
            wb_ack      = ($urandom_range(0, 2) == 0);
            chk_reg_1   = 5'($urandom_range(0, 7));
            chk_reg_2   = 5'($urandom_range(0, 7));
            #1;
            total++;
            if (obs_out() !== exp_out()) begin
                bad++;
                $display("FAIL random i=%0d got=%h want=%h", i, obs_out(), exp_out());
            end
            $display("txn rand i=%0d count=%0d wb=%b:%0d:%h", i, pending_count,
                     wb_write, wb_reg, wb_data);
            tick();
        end
        rst_n = 1;
        idle_inputs();
        drain();
    endtask

    initial begin
        test_reset();
        test_reset_mid_drain();
        test_extend();
        test_full();
        test_lookup();
        test_filter();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
